// File: rtl/regfile_wb_sink_pkg.sv
// Shared definitions for the decode-stage register file (data width `N, address width, FSM states).
`ifndef N
`define N 32
`endif

package regfile_wb_sink_pkg;
    localparam int              REG_ADDR_W = 5;
    localparam int              NREGS      = 32;
    localparam logic [4:0]      REG_X0     = 5'd0;
    localparam logic [4:0]      REG_LAST   = 5'(NREGS - 1);

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;
endpackage

// File: rtl/regfile_wb_sink_clear_seq.sv
// Post-reset clear sequencer: walks x1..x31 writing zero, then parks in READY until the next reset.
module regfile_clear_seq
    import regfile_wb_sink_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  clr_we_o,
    output logic [REG_ADDR_W-1:0] clr_addr_o,
    output logic                  ready_o
);
    rf_state_e             state_q, state_d;
    logic [REG_ADDR_W-1:0] idx_q, idx_d;
    logic                  ready_q, ready_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RF_CLEAR;
            idx_q   <= 5'd1;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        ready_d  = ready_q;
        clr_we_o = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_we_o = 1'b1;
                idx_d    = idx_q + 5'd1;
                // Ready registers on the same edge that zeroes the last entry.
                if (idx_q == REG_LAST) begin
                    state_d = RF_READY;
                    ready_d = 1'b1;
                end
            end
            RF_READY: ;
            default: state_d = RF_CLEAR;
        endcase
    end

    assign clr_addr_o = idx_q;
    assign ready_o    = ready_q;
endmodule

// File: rtl/regfile_wb_sink.sv
// Decode-stage register file fed by Writeback; two registered read ports, x0 hardwired to zero.
// Define RF_BYPASS_EN for write-first forwarding of same-cycle writes onto the read ports.
module regfile_wb_sink
    import regfile_wb_sink_pkg::*;
#(
    parameter int N = `N
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_rf_wr,
    input  logic [REG_ADDR_W-1:0] i_rf_rd,
    input  logic [N-1:0]          i_rf_data,
    input  logic                  i_rd_en,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic [N-1:0]          o_rs1_data,
    output logic [N-1:0]          o_rs2_data,
    output logic                  o_rf_ready,
    output logic                  o_wr_drop
);
    logic [N-1:0]          mem [1:NREGS-1];
    logic                  clr_we;
    logic [REG_ADDR_W-1:0] clr_addr;
    logic                  ready;
    logic                  wr_valid;
    logic                  wb_we;
    logic [N-1:0]          rs1_val, rs2_val;
    logic [N-1:0]          rs1_q, rs2_q;
    logic                  drop_q;

    regfile_clear_seq u_clear_seq (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_we_o   (clr_we),
        .clr_addr_o (clr_addr),
        .ready_o    (ready)
    );

    assign wr_valid = i_rf_wr && (i_rf_rd != REG_X0);
    assign wb_we    = wr_valid && ready;

    // Storage carries no reset; the clear sequencer owns the port until ready.
    always_ff @(posedge clk) begin
        if (clr_we)
            mem[clr_addr] <= '0;
        else if (wb_we)
            mem[i_rf_rd] <= i_rf_data;
    end

    always_comb begin
        rs1_val = (i_rs1 == REG_X0) ? '0 : mem[i_rs1];
        rs2_val = (i_rs2 == REG_X0) ? '0 : mem[i_rs2];
`ifdef RF_BYPASS_EN
        if (wb_we && (i_rf_rd == i_rs1)) rs1_val = i_rf_data;
        if (wb_we && (i_rf_rd == i_rs2)) rs2_val = i_rf_data;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q  <= '0;
            rs2_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            if (i_rd_en && ready) begin
                rs1_q <= rs1_val;
                rs2_q <= rs2_val;
            end
            if (wr_valid && !ready)
                drop_q <= 1'b1;
        end
    end

    assign o_rs1_data = rs1_q;
    assign o_rs2_data = rs2_q;
    assign o_rf_ready = ready;
    assign o_wr_drop  = drop_q;
endmodule
